// File: rtl/pdp6_iob_pkg.sv
// Shared IO-bus definitions for PDP-6 style device responders.
// Holds device codes, CONI bit positions, PI assignment width and the
// transmitter state encoding used by the console teletype.
package pdp6_iob_pkg;

    localparam logic [6:0] DEV_TTY = 7'o120;

    localparam int PIA_W = 3;

    localparam int CONI_TTI_FLAG = 30;
    localparam int CONI_TTO_BUSY = 31;
    localparam int CONI_TTO_FLAG = 32;
    localparam int CONI_PIA_MSB  = 33;
    localparam int CONI_PIA_LSB  = 35;

    localparam int DATA_MSB = 28;
    localparam int DATA_LSB = 35;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_DELAY = 2'd2
    } txState_e;

endpackage

// File: rtl/tty_if.sv
// IO-bus bundle between the processor (master) and a device responder (slave).
// Bit numbering follows the PDP-6 convention: bit 0 is the MSB, bit 35 the LSB.
interface tty_if;

    logic        iob_poweron;
    logic        iob_reset;
    logic        datao_clear;
    logic        datao_set;
    logic        cono_clear;
    logic        cono_set;
    logic        iob_fm_datai;
    logic        iob_fm_status;
    logic [3:9]  ios;
    logic [0:35] iob_in;
    logic [0:35] iob_out;
    logic [1:7]  pi_req;

    modport master (
        output iob_poweron, iob_reset, datao_clear, datao_set,
               cono_clear, cono_set, iob_fm_datai, iob_fm_status, ios, iob_in,
        input  iob_out, pi_req
    );

    modport slave (
        input  iob_poweron, iob_reset, datao_clear, datao_set,
               cono_clear, cono_set, iob_fm_datai, iob_fm_status, ios, iob_in,
        output iob_out, pi_req
    );

endinterface

// File: rtl/tty_xmit.sv
// Teletype transmitter: presents one latched character on a valid/ready port
// and reports completion. With TTY_CHAR_DELAY_EN defined, a line-speed pacing
// delay of CHAR_DELAY clocks follows each accepted character.
module tty_xmit
    import pdp6_iob_pkg::*;
#(
    parameter logic [15:0] CHAR_DELAY = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       tx_ready_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    output logic       done_o
);

    txState_e   state_q, state_d;
    logic [7:0] txData_q;
    logic       cntDone;

`ifdef TTY_CHAR_DELAY_EN
    logic [15:0] cnt_q;

    // Pacing counter runs only while in DELAY and restarts from zero each time
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else if (state_q == TX_DELAY) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            cnt_q <= 16'd0;
        end
    end

    assign cntDone = ({1'b0, cnt_q} + 17'd1) >= {1'b0, CHAR_DELAY};
`else
    localparam logic unusedCharDelay = |CHAR_DELAY;
    assign cntDone = 1'b0;
`endif

    // State register and character latch; the character is captured only when a send starts
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            txData_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == TX_IDLE && start_i) begin
                txData_q <= data_i;
            end
        end
    end

    // Next-state: a start is ignored unless idle; the host handshake ends SEND
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: begin
                if (start_i) state_d = TX_SEND;
            end
            TX_SEND: begin
`ifdef TTY_CHAR_DELAY_EN
                if (tx_ready_i) state_d = TX_DELAY;
`else
                if (tx_ready_i) state_d = TX_IDLE;
`endif
            end
            TX_DELAY: begin
                if (cntDone) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs: valid throughout SEND, done on the cycle that returns to IDLE
    always_comb begin
        tx_valid_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            TX_SEND: begin
                tx_valid_o = 1'b1;
`ifndef TTY_CHAR_DELAY_EN
                done_o = tx_ready_i;
`endif
            end
            TX_DELAY: done_o = cntDone;
            default: ;
        endcase
    end

    assign tx_data_o = txData_q;

endmodule

// File: rtl/tty.sv
// Console teletype IO-bus responder: CONO/CONI/DATAO/DATAI decode for one
// device code, receiver buffer, and PI request generation. The transmitter
// lives in tty_xmit. Optional line pacing is enabled with TTY_CHAR_DELAY_EN.
module tty
    import pdp6_iob_pkg::*;
#(
    parameter logic [6:0]  DEVCODE    = DEV_TTY,
    parameter logic [15:0] CHAR_DELAY = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    tty_if.slave       iobus,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    logic             sel, clrAll, dataiLvl, dataiEdge, rxAccept, xmitDone, xmitStart;
    logic [PIA_W-1:0] pia_q, pia_d;
    logic             ttoFlag_q, ttoFlag_d, ttoBusy_q, ttoBusy_d, ttiFlag_q, ttiFlag_d;
    logic [7:0]       ttoBuf_q, ttoBuf_d, ttiBuf_q, ttiBuf_d;
    logic             dataiLvl_q;
    logic [0:35]      iobOut;
    logic [1:7]       piReq;
    logic             unusedIobIn;

    assign unusedIobIn = ^iobus.iob_in[0:27];

    assign sel       = (iobus.ios == DEVCODE);
    assign clrAll    = reset | iobus.iob_reset | ~iobus.iob_poweron;
    assign dataiLvl  = iobus.iob_fm_datai & sel;
    assign dataiEdge = dataiLvl & ~dataiLvl_q;
    assign rx_ready  = ~ttiFlag_q;
    assign rxAccept  = rx_valid & rx_ready;
    assign xmitStart = sel & iobus.datao_set;

    tty_xmit #(.CHAR_DELAY(CHAR_DELAY)) u_xmit (
        .clk        (clk),
        .reset      (clrAll),
        .start_i    (xmitStart),
        .data_i     (ttoBuf_d),
        .tx_ready_i (tx_ready),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .done_o     (xmitDone)
    );

    // Register updates: clear pulses before set pulses, transmitter completion last
    always_comb begin
        pia_d     = pia_q;
        ttoFlag_d = ttoFlag_q;
        ttoBusy_d = ttoBusy_q;
        ttiFlag_d = ttiFlag_q;
        ttoBuf_d  = ttoBuf_q;
        ttiBuf_d  = ttiBuf_q;
        if (sel && iobus.cono_clear) begin
            pia_d     = '0;
            ttoFlag_d = 1'b0;
            ttiFlag_d = 1'b0;
        end
        if (sel && iobus.cono_set) begin
            pia_d     = pia_d | iobus.iob_in[CONI_PIA_MSB:CONI_PIA_LSB];
            ttoFlag_d = ttoFlag_d | iobus.iob_in[CONI_TTO_FLAG];
            ttiFlag_d = ttiFlag_d | iobus.iob_in[CONI_TTI_FLAG];
        end
        if (sel && iobus.datao_clear) begin
            ttoBuf_d = 8'd0;
        end
        if (sel && iobus.datao_set) begin
            ttoBuf_d  = ttoBuf_d | iobus.iob_in[DATA_MSB:DATA_LSB];
            ttoBusy_d = 1'b1;
            ttoFlag_d = 1'b0;
        end
        if (xmitDone) begin
            ttoBusy_d = 1'b0;
            ttoFlag_d = 1'b1;
        end
        if (dataiEdge) begin
            ttiFlag_d = 1'b0;
        end
        if (rxAccept) begin
            ttiFlag_d = 1'b1;
            ttiBuf_d  = rx_data;
        end
    end

    // Device registers; any of the three reset sources clears everything
    always_ff @(posedge clk) begin
        if (clrAll) begin
            pia_q      <= '0;
            ttoFlag_q  <= 1'b0;
            ttoBusy_q  <= 1'b0;
            ttiFlag_q  <= 1'b0;
            ttoBuf_q   <= 8'd0;
            ttiBuf_q   <= 8'd0;
            dataiLvl_q <= 1'b0;
        end else begin
            pia_q      <= pia_d;
            ttoFlag_q  <= ttoFlag_d;
            ttoBusy_q  <= ttoBusy_d;
            ttiFlag_q  <= ttiFlag_d;
            ttoBuf_q   <= ttoBuf_d;
            ttiBuf_q   <= ttiBuf_d;
            dataiLvl_q <= dataiLvl;
        end
    end

    // Read-back mux: status and data words, zero unless selected and reading
    always_comb begin
        iobOut = '0;
        if (sel && iobus.iob_fm_status) begin
            iobOut[CONI_TTI_FLAG]              = ttiFlag_q;
            iobOut[CONI_TTO_BUSY]              = ttoBusy_q;
            iobOut[CONI_TTO_FLAG]              = ttoFlag_q;
            iobOut[CONI_PIA_MSB:CONI_PIA_LSB]  = pia_q;
        end
        if (sel && iobus.iob_fm_datai) begin
            iobOut[DATA_MSB:DATA_LSB] = iobOut[DATA_MSB:DATA_LSB] | ttiBuf_q;
        end
    end

    // One-hot PI request on the assigned channel while either flag is up
    always_comb begin
        piReq = '0;
        for (int i = 1; i <= 7; i++) begin
            if (pia_q == 3'(i)) begin
                piReq[i] = ttiFlag_q | ttoFlag_q;
            end
        end
    end

    assign iobus.iob_out = iobOut;
    assign iobus.pi_req  = piReq;

endmodule
